// File: rtl/input_dma_controller_pkg.sv
// Shared types and constants for the input DMA controller: FSM encoding,
// default memory-map location and the word-count helper.
package input_dma_controller_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    COPY = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_BASE_ADDR = 7802;

  // Ceiling division: how many width-bit words hold count bits.
  function automatic int words_for(input int count, input int width);
    return (count + width - 1) / width;
  endfunction

endpackage

// File: rtl/input_dma_controller_debouncer.sv
// One input channel: 2-FF synchroniser, stability counter and an optional
// sticky press latch that is cleared when the controller takes a snapshot.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit STICKY          = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  input  logic i_clear,
  output logic o_report
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  // The counter only runs while the synchronised value differs from the
  // debounced level, so any bounce back to the old level restarts it.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values and the synchroniser really is two stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  if (STICKY) begin : g_sticky
    logic r_latch;

    // A press seen in the snapshot cycle survives the clear.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_latch <= 1'b0;
      end else begin
        r_latch <= r_level | (r_latch & ~i_clear);
      end
    end

    assign o_report = r_level | r_latch;
  end else begin : g_plain
    logic w_unused_clear;
    assign w_unused_clear = i_clear;
    assign o_report       = r_level;
  end

endmodule

// File: rtl/input_dma_controller.sv
// Snapshots INPUT_COUNT debounced inputs on copy_start and streams them to
// the data-memory write port, one word per cycle, starting at BASE_ADDR.
module input_dma_controller
  import input_dma_controller_pkg::*;
#(
  parameter int INPUT_COUNT     = 6,
  parameter int BASE_ADDR       = DEFAULT_BASE_ADDR,
  parameter int ADDR_WIDTH      = 13,
  parameter int DATA_WIDTH      = 16,
  parameter bit PACKED          = 1'b0,
  parameter bit STICKY          = 1'b0,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   copy_start,
  input  logic [INPUT_COUNT-1:0] inputs_in,
  output logic                   mem_dout_we,
  output logic [ADDR_WIDTH-1:0]  mem_dout_addr,
  output logic [DATA_WIDTH-1:0]  mem_dout,
  output logic                   busy,
  output logic                   done
);

  localparam int WORDS = PACKED ? words_for(INPUT_COUNT, DATA_WIDTH) : INPUT_COUNT;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(WORDS - 1);

  state_e                  r_state;
  state_e                  w_state_next;
  logic [INPUT_COUNT-1:0]  r_snap;
  logic [INPUT_COUNT-1:0]  w_report;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_done;
  logic                    w_accept;
  logic                    w_last;

  assign w_accept = (r_state == IDLE) && copy_start;
  assign w_last   = (r_state == COPY) && (r_idx == LAST_IDX);

  for (genvar g = 0; g < INPUT_COUNT; g++) begin : g_in
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .STICKY         (STICKY)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (inputs_in[g]),
      .i_clear (w_accept),
      .o_report(w_report[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: next state defaults to the current state before the case so that
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (copy_start) w_state_next = COPY;
      COPY:    if (r_idx == LAST_IDX) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: the snapshot register is reset explicitly; it feeds mem_dout
  // outside COPY, which must never carry X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snap <= '0;
      r_addr <= BASE;
      r_idx  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_snap <= w_report;
        r_addr <= BASE;
        r_idx  <= '0;
      end else if ((r_state == COPY) && !w_last) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
        r_idx  <= r_idx + IDX_W'(1);
      end
    end
  end

  assign mem_dout_we   = (r_state == COPY);
  assign busy          = (r_state == COPY);
  assign done          = r_done;
  assign mem_dout_addr = r_addr;

  if (PACKED) begin : g_packed
    localparam int PAD_W = WORDS * DATA_WIDTH;
    logic [PAD_W-1:0] w_padded;
    // Bits above INPUT_COUNT in the last word read as zero.
    assign w_padded = PAD_W'(r_snap);
    assign mem_dout = w_padded[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];
  end else begin : g_unpacked
    assign mem_dout = {DATA_WIDTH{r_snap[r_idx]}};
  end

endmodule
